// File: rtl/exit_queue.sv
`default_nettype none
// ============================================================================
// Module   : exit_queue
// Brief    : Per-egress-port frame queue. Words are written speculatively,
//            committed on a good in_last (length pushed to a length FIFO) or
//            rewound on a drop. Complete frames are replayed over a
//            valid/ready stream.
// Revision : 1.0  initial release
// ============================================================================
module exit_queue #(
  parameter int DEPTH_WORDS     = 256,
  parameter int LEN_DEPTH       = 32,
  parameter int MAX_FRAME_BYTES = 1536
) (
  input  logic         clk_ram_ctl,
  input  logic         rst_ram_ctl,
  input  logic         in_sel,
  input  logic [10:0]  in_len,
  input  logic         in_valid,
  input  logic         in_last,
  input  logic [127:0] in_data,
  output logic         space_avail,
  output logic         rd_valid,
  input  logic         rd_ready,
  output logic [127:0] rd_data,
  output logic         rd_last,
  output logic [4:0]   rd_bytes,
  output logic [10:0]  rd_len,
  output logic [15:0]  drop_count
);

  localparam int          c_aw        = $clog2(DEPTH_WORDS);
  localparam int          c_law       = $clog2(LEN_DEPTH);
  localparam logic [15:0] c_max_words = 16'((MAX_FRAME_BYTES + 15) / 16);
  localparam logic [15:0] c_depth16   = 16'(DEPTH_WORDS);
  localparam logic [10:0] c_max_len   = 11'(MAX_FRAME_BYTES);
  localparam logic [c_aw:0]  c_ptr_one = {{c_aw{1'b0}}, 1'b1};
  localparam logic [c_law:0] c_lf_one  = {{c_law{1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FETCH  = 2'd1,
    ST_STREAM = 2'd2
  } rd_state_t;

  // Storage
  logic [127:0] r_mem     [DEPTH_WORDS];
  logic [10:0]  r_len_mem [LEN_DEPTH];

  // Write-side state
  logic [c_aw:0]  r_wr_ptr;
  logic [c_aw:0]  r_wr_commit;
  logic [c_law:0] r_lf_wp;
  logic           r_in_frame;
  logic           r_drop;
  logic [15:0]    r_need;
  logic [15:0]    r_cnt;
  logic [10:0]    r_len;
  logic [15:0]    r_drop_cnt;
  logic           r_space;

  // Read-side state
  rd_state_t      r_state;
  logic [c_aw:0]  r_rd_ptr;
  logic [c_law:0] r_lf_rp;
  logic [7:0]     r_remain;
  logic           r_rd_valid;
  logic           r_rd_last;
  logic [4:0]     r_rd_bytes;
  logic [10:0]    r_rd_len;
  logic [127:0]   r_rd_data;

  logic [c_aw:0]  w_used;
  logic [15:0]    w_free;
  logic           w_lf_full;
  logic           w_lf_empty;
  logic           w_accept;
  logic           w_first;
  logic [15:0]    w_need_first;
  logic           w_len_bad;
  logic           w_first_bad;
  logic [15:0]    w_need;
  logic [15:0]    w_cnt_prev;
  logic [15:0]    w_cnt_next;
  logic           w_drop;
  logic           w_write;
  logic           w_commit;
  logic           w_discard;
  logic [10:0]    w_len_cur;
  logic [10:0]    w_pop_len;
  logic [7:0]     w_pop_words;
  logic [4:0]     w_last_bytes;
  logic [c_aw:0]  w_rd_next;

  // Occupancy uses pointers one bit wider than the address so full != empty.
  assign w_used     = r_wr_ptr - r_rd_ptr;
  assign w_free     = c_depth16 - 16'(w_used);
  assign w_lf_full  = (r_lf_wp[c_law] != r_lf_rp[c_law]) &&
                      (r_lf_wp[c_law-1:0] == r_lf_rp[c_law-1:0]);
  assign w_lf_empty = (r_lf_wp == r_lf_rp);

  // Admission checks happen on the first word; later words only count.
  assign w_accept     = in_sel && in_valid;
  assign w_first      = w_accept && !r_in_frame;
  assign w_need_first = (16'(in_len) + 16'd15) >> 4;
  assign w_len_bad    = (in_len == 11'd0) || (in_len > c_max_len);
  assign w_first_bad  = w_len_bad || (w_free < w_need_first) || w_lf_full;
  assign w_need       = w_first ? w_need_first : r_need;
  assign w_cnt_prev   = w_first ? 16'd0 : r_cnt;
  assign w_cnt_next   = (w_cnt_prev == 16'hFFFF) ? w_cnt_prev : w_cnt_prev + 16'd1;
  // Words past the declared length are never written: space was only
  // reserved for 'need' words, so extra writes could clobber unread data.
  assign w_drop       = w_first ? w_first_bad : (r_drop || (r_cnt >= r_need));
  assign w_write      = w_accept && !w_drop;
  assign w_commit     = w_write && in_last && (w_cnt_next == w_need);
  assign w_discard    = w_accept && in_last && !w_commit;
  assign w_len_cur    = w_first ? in_len : r_len;

  assign w_pop_len    = r_len_mem[r_lf_rp[c_law-1:0]];
  assign w_pop_words  = 8'((12'(w_pop_len) + 12'd15) >> 4);
  assign w_last_bytes = (r_rd_len[3:0] == 4'd0) ? 5'd16 : {1'b0, r_rd_len[3:0]};
  assign w_rd_next    = r_rd_ptr + c_ptr_one;

  // Frame and length storage writes (no reset needed on RAM contents).
  always_ff @(posedge clk_ram_ctl) begin
    if (w_write) r_mem[r_wr_ptr[c_aw-1:0]] <= in_data;
    if (w_commit) r_len_mem[r_lf_wp[c_law-1:0]] <= w_len_cur;
  end

  // Write side: speculative pointer, commit on good end, rewind on drop.
  always_ff @(posedge clk_ram_ctl or posedge rst_ram_ctl) begin
    if (rst_ram_ctl) begin
      r_wr_ptr    <= '0;
      r_wr_commit <= '0;
      r_lf_wp     <= '0;
      r_in_frame  <= 1'b0;
      r_drop      <= 1'b0;
      r_need      <= 16'd0;
      r_cnt       <= 16'd0;
      r_len       <= 11'd0;
      r_drop_cnt  <= 16'd0;
    end else begin
      if (w_accept) begin
        r_in_frame <= !in_last;
        r_drop     <= w_drop;
        r_cnt      <= w_cnt_next;
        if (w_first) begin
          r_need <= w_need_first;
          r_len  <= in_len;
        end
      end
      if (w_write) r_wr_ptr <= r_wr_ptr + c_ptr_one;
      if (w_commit) begin
        r_wr_commit <= r_wr_ptr + c_ptr_one;
        r_lf_wp     <= r_lf_wp + c_lf_one;
      end
      if (w_discard) begin
        r_wr_ptr <= r_wr_commit;
        if (r_drop_cnt != 16'hFFFF) r_drop_cnt <= r_drop_cnt + 16'd1;
      end
    end
  end

  // Registered advertisement of room for one maximum-size frame.
  always_ff @(posedge clk_ram_ctl or posedge rst_ram_ctl) begin
    if (rst_ram_ctl) r_space <= 1'b0;
    else             r_space <= (w_free >= c_max_words) && !w_lf_full;
  end

  // Read FSM: pop a length, fetch the first word, then stream with prefetch.
  always_ff @(posedge clk_ram_ctl or posedge rst_ram_ctl) begin
    if (rst_ram_ctl) begin
      r_state    <= ST_IDLE;
      r_rd_ptr   <= '0;
      r_lf_rp    <= '0;
      r_remain   <= 8'd0;
      r_rd_valid <= 1'b0;
      r_rd_last  <= 1'b0;
      r_rd_bytes <= 5'd0;
      r_rd_len   <= 11'd0;
      r_rd_data  <= 128'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (!w_lf_empty) begin
            r_rd_len <= w_pop_len;
            r_remain <= w_pop_words;
            r_lf_rp  <= r_lf_rp + c_lf_one;
            r_state  <= ST_FETCH;
          end
        end
        ST_FETCH: begin
          r_rd_data  <= r_mem[r_rd_ptr[c_aw-1:0]];
          r_rd_valid <= 1'b1;
          r_rd_last  <= (r_remain == 8'd1);
          r_rd_bytes <= (r_remain == 8'd1) ? w_last_bytes : 5'd16;
          r_state    <= ST_STREAM;
        end
        ST_STREAM: begin
          if (rd_ready) begin
            r_rd_ptr <= w_rd_next;
            if (r_rd_last) begin
              r_rd_valid <= 1'b0;
              r_rd_last  <= 1'b0;
              r_rd_bytes <= 5'd0;
              r_state    <= ST_IDLE;
            end else begin
              r_rd_data  <= r_mem[w_rd_next[c_aw-1:0]];
              r_remain   <= r_remain - 8'd1;
              r_rd_last  <= (r_remain == 8'd2);
              r_rd_bytes <= (r_remain == 8'd2) ? w_last_bytes : 5'd16;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign space_avail = r_space;
  assign rd_valid    = r_rd_valid;
  assign rd_data     = r_rd_data;
  assign rd_last     = r_rd_last;
  assign rd_bytes    = r_rd_bytes;
  assign rd_len      = r_rd_len;
  assign drop_count  = r_drop_cnt;

endmodule
`default_nettype wire

// File: tb/tb_exit_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_exit_queue
// Brief    : Scoreboard bench for exit_queue: a 256-word instance for
//            latency, drops, back-pressure, fill and reset, and a 16-word
//            instance for pointer wrap-around.
// Revision : 1.0  initial release
// ============================================================================
module tb_exit_queue;

  logic clk_ram_ctl = 1'b0;
  logic rst_ram_ctl;
  always #5 clk_ram_ctl = ~clk_ram_ctl;

  logic         a_sel, a_valid, a_last, a_ready;
  logic [10:0]  a_len;
  logic [127:0] a_data;
  logic         a_space, a_rd_valid, a_rd_last;
  logic [127:0] a_rd_data;
  logic [4:0]   a_rd_bytes;
  logic [10:0]  a_rd_len;
  logic [15:0]  a_drops;

  logic         b_sel, b_valid, b_last, b_ready;
  logic [10:0]  b_len;
  logic [127:0] b_data;
  logic         b_space, b_rd_valid, b_rd_last;
  logic [127:0] b_rd_data;
  logic [4:0]   b_rd_bytes;
  logic [10:0]  b_rd_len;
  logic [15:0]  b_drops;

  exit_queue u_dut_a (
    .clk_ram_ctl(clk_ram_ctl), .rst_ram_ctl(rst_ram_ctl),
    .in_sel(a_sel), .in_len(a_len), .in_valid(a_valid), .in_last(a_last),
    .in_data(a_data), .space_avail(a_space), .rd_valid(a_rd_valid),
    .rd_ready(a_ready), .rd_data(a_rd_data), .rd_last(a_rd_last),
    .rd_bytes(a_rd_bytes), .rd_len(a_rd_len), .drop_count(a_drops)
  );

  exit_queue #(.DEPTH_WORDS(16)) u_dut_b (
    .clk_ram_ctl(clk_ram_ctl), .rst_ram_ctl(rst_ram_ctl),
    .in_sel(b_sel), .in_len(b_len), .in_valid(b_valid), .in_last(b_last),
    .in_data(b_data), .space_avail(b_space), .rd_valid(b_rd_valid),
    .rd_ready(b_ready), .rd_data(b_rd_data), .rd_last(b_rd_last),
    .rd_bytes(b_rd_bytes), .rd_len(b_rd_len), .drop_count(b_drops)
  );

  typedef struct packed {
    logic [127:0] data;
    logic         last;
    logic [4:0]   bytes;
    logic [10:0]  len;
  } item_t;

  typedef struct {
    int len;
    int nw;
    bit drop;
  } vec_t;

  item_t sb_a[$];
  item_t sb_b[$];
  int    total = 0;
  int    bad   = 0;
  int    a_rmode = 3;   // 0 ready, 1 toggle, 2 random, 3 stalled
  int    b_reads = 0;

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] mk(input int fid, input int w);
    return {32'(fid), 32'(w), 32'(fid * 131 + w), 32'hC0FFEE00 ^ 32'(w)};
  endfunction

  function automatic logic [4:0] lastb(input int len);
    return (len % 16 == 0) ? 5'd16 : 5'(len % 16);
  endfunction

  function automatic item_t mkitem(input int fid, input int w, input int nw, input int len);
    item_t it;
    it.data  = mk(fid, w);
    it.last  = (w == nw - 1);
    it.bytes = (w == nw - 1) ? lastb(len) : 5'd16;
    it.len   = 11'(len);
    return it;
  endfunction

  // Consumer ready patterns, updated 2 time units after each edge
  initial begin
    a_ready = 1'b0;
    b_ready = 1'b0;
    forever begin
      @(posedge clk_ram_ctl);
      #2;
      case (a_rmode)
        0:       a_ready = 1'b1;
        1:       a_ready = ~a_ready;
        2:       a_ready = 1'($urandom_range(0, 1));
        default: a_ready = 1'b0;
      endcase
      b_ready = 1'($urandom_range(0, 1));
    end
  end

  // Monitor A: scoreboard pop on handshake, hold check under stall, gap measure
  logic         a_pv, a_pr;
  logic [144:0] a_pdat;
  bit           a_in_gap;
  int           a_gap_cnt, a_last_gap;
  initial begin a_pv = 0; a_pr = 0; a_pdat = '0; a_in_gap = 0; a_gap_cnt = 0; a_last_gap = -1; end

  always @(negedge clk_ram_ctl) begin
    if (rst_ram_ctl) begin
      a_pv = 0; a_pr = 0; a_in_gap = 0;
    end else begin
      if (a_pv && !a_pr) begin
        chk("hold_valid", a_rd_valid, 1'b1);
        chk("hold_data", {a_rd_data, a_rd_last, a_rd_bytes, a_rd_len}, a_pdat);
      end
      if (a_in_gap) begin
        if (a_rd_valid) begin a_last_gap = a_gap_cnt; a_in_gap = 0; end
        else a_gap_cnt++;
      end
      if (a_rd_valid && a_ready) begin
        if (sb_a.size() == 0) begin
          total++; bad++;
          $display("FAIL word_a unexpected actual=%0h required=none", a_rd_data);
        end else begin
          chk("word_a", {a_rd_data, a_rd_last, a_rd_bytes, a_rd_len}, sb_a.pop_front());
        end
        if (a_rd_last) begin a_in_gap = 1; a_gap_cnt = 0; end
      end
      a_pv = a_rd_valid; a_pr = a_ready;
      a_pdat = {a_rd_data, a_rd_last, a_rd_bytes, a_rd_len};
    end
  end

  // Monitor B: scoreboard pop on handshake
  always @(negedge clk_ram_ctl) begin
    if (!rst_ram_ctl && b_rd_valid && b_ready) begin
      b_reads++;
      if (sb_b.size() == 0) begin
        total++; bad++;
        $display("FAIL word_b unexpected actual=%0h required=none", b_rd_data);
      end else begin
        chk("word_b", {b_rd_data, b_rd_last, b_rd_bytes, b_rd_len}, sb_b.pop_front());
      end
    end
  end

  task automatic send_a(input int fid, input int len, input int nw, input bit good);
    for (int w = 0; w < nw; w++) begin
      @(posedge clk_ram_ctl); #1;
      a_sel = 1'b1; a_valid = 1'b1; a_len = 11'(len);
      a_last = (w == nw - 1); a_data = mk(fid, w);
      if (good) sb_a.push_back(mkitem(fid, w, nw, len));
    end
    @(posedge clk_ram_ctl); #1;
    a_sel = 1'b0; a_valid = 1'b0; a_last = 1'b0;
  endtask

  task automatic wait_drain_a(input int bound);
    int n = 0;
    while ((sb_a.size() != 0 || a_rd_valid) && n < bound) begin
      @(posedge clk_ram_ctl); #1;
      n++;
    end
    chk("drain_a", sb_a.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    vec_t vecs[12];
    int   exp_drops;
    int   k, n, b_committed;

    vecs[0]  = '{100, 7, 0};   vecs[1]  = '{16, 1, 0};
    vecs[2]  = '{17, 2, 0};    vecs[3]  = '{1600, 3, 1};
    vecs[4]  = '{64, 3, 1};    vecs[5]  = '{64, 4, 0};
    vecs[6]  = '{0, 1, 1};     vecs[7]  = '{64, 5, 1};
    vecs[8]  = '{1536, 96, 0}; vecs[9]  = '{2047, 4, 1};
    vecs[10] = '{31, 2, 0};    vecs[11] = '{1, 1, 0};

    rst_ram_ctl = 1'b1;
    a_sel = 0; a_valid = 0; a_last = 0; a_len = '0; a_data = '0;
    b_sel = 0; b_valid = 0; b_last = 0; b_len = '0; b_data = '0;

    // Reset state
    repeat (3) @(posedge clk_ram_ctl);
    #1;
    chk("rst_space", a_space, 1'b0);
    chk("rst_valid", a_rd_valid, 1'b0);
    chk("rst_last", a_rd_last, 1'b0);
    chk("rst_bytes", a_rd_bytes, 5'd0);
    chk("rst_len", a_rd_len, 11'd0);
    chk("rst_data", a_rd_data, 128'd0);
    chk("rst_drops", a_drops, 16'd0);
    rst_ram_ctl = 1'b0;
    @(posedge clk_ram_ctl); #1;
    chk("space_after_reset", a_space, 1'b1);

    // Single frame and commit-to-valid latency
    a_rmode = 0;
    send_a(1, 100, 7, 1);
    k = 0;
    do begin
      @(posedge clk_ram_ctl); #1;
      k++;
    end while (!a_rd_valid && k < 20);
    chk("commit_to_valid", k, 2);
    wait_drain_a(100);
    chk("drops_single", a_drops, 16'd0);

    // Table of good and bad frames with random back-pressure
    a_rmode = 2;
    exp_drops = 0;
    for (int i = 0; i < 12; i++) begin
      send_a(10 + i, vecs[i].len, vecs[i].nw, !vecs[i].drop);
      if (vecs[i].drop) exp_drops++;
      chk($sformatf("drops_vec%0d", i), a_drops, exp_drops);
    end
    wait_drain_a(2000);

    // Back-pressure and inter-frame gap
    a_rmode = 3;
    a_last_gap = -1;
    send_a(40, 64, 4, 1);
    send_a(41, 64, 4, 1);
    a_rmode = 1;
    wait_drain_a(200);
    chk("frame_gap", a_last_gap, 2);

    // Fill until space_avail drops, then drain and watch it return
    a_rmode = 3;
    @(posedge clk_ram_ctl); #1;
    chk("space_idle", a_space, 1'b1);
    n = 0;
    while (a_space && n < 4) begin
      send_a(60 + n, 1536, 96, 1);
      n++;
      @(posedge clk_ram_ctl); #1;
    end
    chk("fill_frames", n, 2);
    chk("fill_space_low", a_space, 1'b0);
    a_rmode = 0;
    k = 0;
    do begin
      @(posedge clk_ram_ctl); #1;
      k++;
    end while (!a_space && k < 60);
    chk("space_reassert_cycle", k, 33);
    wait_drain_a(400);

    // Wrap-around on the 16-word instance with concurrent random reads
    b_committed = 0;
    for (int f = 0; f < 20; f++) begin
      n = 0;
      while ((b_committed - b_reads) > 11 && n < 200) begin
        @(posedge clk_ram_ctl); #1;
        n++;
      end
      chk("wrap_wait", n < 200, 1'b1);
      for (int w = 0; w < 5; w++) begin
        @(posedge clk_ram_ctl); #1;
        b_sel = 1'b1; b_valid = 1'b1; b_len = 11'd80;
        b_last = (w == 4); b_data = mk(100 + f, w);
        sb_b.push_back(mkitem(100 + f, w, 5, 80));
      end
      @(posedge clk_ram_ctl); #1;
      b_sel = 1'b0; b_valid = 1'b0; b_last = 1'b0;
      b_committed += 5;
    end
    n = 0;
    while ((sb_b.size() != 0 || b_rd_valid) && n < 500) begin
      @(posedge clk_ram_ctl); #1;
      n++;
    end
    chk("drain_b", sb_b.size(), 0);
    chk("drops_b", b_drops, 16'd0);
    chk("reads_b", b_reads, 100);

    // Asynchronous reset mid-frame with a word held on the read side
    a_rmode = 3;
    send_a(50, 64, 4, 1);
    repeat (3) @(posedge clk_ram_ctl);
    #1;
    chk("prereset_valid", a_rd_valid, 1'b1);
    for (int w = 0; w < 3; w++) begin
      @(posedge clk_ram_ctl); #1;
      a_sel = 1'b1; a_valid = 1'b1; a_len = 11'd96;
      a_last = 1'b0; a_data = mk(51, w);
    end
    #2;
    rst_ram_ctl = 1'b1;
    #1;
    chk("arst_space", a_space, 1'b0);
    chk("arst_valid", a_rd_valid, 1'b0);
    chk("arst_last", a_rd_last, 1'b0);
    chk("arst_bytes", a_rd_bytes, 5'd0);
    chk("arst_len", a_rd_len, 11'd0);
    chk("arst_data", a_rd_data, 128'd0);
    chk("arst_drops", a_drops, 16'd0);
    sb_a.delete();
    @(posedge clk_ram_ctl); #1;
    a_sel = 1'b0; a_valid = 1'b0; a_last = 1'b0;
    repeat (2) @(posedge clk_ram_ctl);
    #1;
    rst_ram_ctl = 1'b0;
    a_rmode = 0;
    send_a(52, 80, 5, 1);
    wait_drain_a(100);
    chk("post_reset_drops", a_drops, 16'd0);
    chk("post_reset_space", a_space, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
